// File: rtl/cv32e40p_rf_scan_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cv32e40p_rf_scan_pkg
//  Description : Shared definitions for the register-file scan reader: FSM
//                state encoding, frame framing constants, CRC-8 polynomial
//                and a helper returning the total number of bits in a frame.
//                The optional CRC trailer is enabled by defining
//                CV32E40P_RF_SCAN_CRC_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
package cv32e40p_rf_scan_pkg;

    // Frame start pattern length and CRC trailer length, in bits.
    localparam int unsigned HDR_BITS       = 8;
    localparam int unsigned CRC_BITS       = 8;

    // Default frame start pattern, transmitted LSB first.
    localparam logic [7:0]  DEFAULT_HEADER = 8'hA5;

    // CRC-8 generator polynomial x^8 + x^2 + x + 1 (implicit x^8 term).
    localparam logic [7:0]  CRC8_POLY      = 8'h07;

    // Frame sequencer states. ST_CRC is only reachable when the CRC
    // trailer is compiled in.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_DATA = 2'd2,
        ST_CRC  = 2'd3
    } scan_state_e;

    // Total number of serial bits in one frame.
    function automatic int unsigned frame_bits(
        input int unsigned num_regs,
        input int unsigned data_width,
        input bit          crc_en
    );
        return HDR_BITS + num_regs * data_width + (crc_en ? CRC_BITS : 32'd0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/cv32e40p_rf_scan_crc8.sv
`default_nettype none
// ============================================================================
//  Module      : cv32e40p_rf_scan_crc8
//  Description : Bit-serial CRC-8 accumulator (MSB-shifting LFSR, init 0).
//                'clear' zeroes the register, 'enable' folds bit_in in.
//                'crc_next' exposes the value the register takes if bit_in
//                is folded in this cycle, so a consumer can emit the final
//                CRC in the same cycle the last data bit is accepted.
//  Ports       : clk, rst        - clock, synchronous active-high reset
//                clear           - restart accumulation from zero
//                enable, bit_in  - fold one message bit
//                crc, crc_next   - current and look-ahead CRC value
//  Revision    : 1.0 - initial release
// ============================================================================
module cv32e40p_rf_scan_crc8
    import cv32e40p_rf_scan_pkg::*;
#(
    parameter logic [7:0] POLY = CRC8_POLY
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       enable,
    input  logic       bit_in,
    output logic [7:0] crc,
    output logic [7:0] crc_next
);

    logic w_fb;

    assign w_fb     = crc[7] ^ bit_in;
    assign crc_next = {crc[6:0], 1'b0} ^ (w_fb ? POLY : 8'h00);

    always_ff @(posedge clk) begin
        if (rst) begin
            crc <= 8'h00;
        end else if (clear) begin
            crc <= 8'h00;
        end else if (enable) begin
            crc <= crc_next;
        end
    end

endmodule
`default_nettype wire

// File: rtl/cv32e40p_rf_scan_reader.sv
`default_nettype none
// ============================================================================
//  Module      : cv32e40p_rf_scan_reader
//  Description : Snapshots the packed register-file scan view on capture_i
//                and streams it as a framed serial bit stream over a
//                valid/ready channel: 8-bit header (LSB first), then every
//                bit of the snapshot (register 0 first, bit 0 first), and,
//                when CV32E40P_RF_SCAN_CRC_EN is defined, a CRC-8 trailer
//                over the data bits (crc[0] first).
//  Ports       : clk, rst       - clock, synchronous active-high reset
//                mem_scan_i     - packed register-file scan view
//                capture_i      - request a snapshot and frame
//                scan_dout_o    - serial bit, valid with scan_valid_o
//                scan_valid_o   - bit valid; scan_ready_i accepts it
//                scan_last_o    - current bit closes the frame
//                busy_o         - frame in progress
//                done_o         - final bit accepted this cycle
//                overrun_o      - sticky: capture requested while busy
//  Macros      : CV32E40P_RF_SCAN_CRC_EN - append CRC-8 trailer
//  Revision    : 1.0 - initial release
// ============================================================================
module cv32e40p_rf_scan_reader
    import cv32e40p_rf_scan_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned NUM_SCAN_REGS = 9,
    parameter logic [7:0]  HEADER        = DEFAULT_HEADER
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic [NUM_SCAN_REGS-1:0][DATA_WIDTH-1:0] mem_scan_i,
    input  logic                                    capture_i,
    output logic                                    scan_dout_o,
    output logic                                    scan_valid_o,
    input  logic                                    scan_ready_i,
    output logic                                    scan_last_o,
    output logic                                    busy_o,
    output logic                                    done_o,
    output logic                                    overrun_o
);

    localparam int unsigned        c_DATA_BITS = NUM_SCAN_REGS * DATA_WIDTH;
    localparam int unsigned        c_IDX_W     = $clog2(c_DATA_BITS);
    localparam logic [c_IDX_W-1:0] c_LAST_IDX  = c_IDX_W'(c_DATA_BITS - 1);
    localparam logic [2:0]         c_HDR_LAST  = 3'(HDR_BITS - 1);

`ifdef CV32E40P_RF_SCAN_CRC_EN
    localparam bit                 c_CRC_EN    = 1'b1;
    localparam logic [2:0]         c_CRC_LAST  = 3'(CRC_BITS - 1);
`else
    localparam bit                 c_CRC_EN    = 1'b0;
`endif

    scan_state_e              r_state;
    logic [c_DATA_BITS-1:0]   r_shadow;
    logic [c_IDX_W-1:0]       r_bit_idx;
    logic [2:0]               r_sub_idx;   // header / CRC bit position
    logic                     r_dout;
    logic                     r_valid;
    logic                     r_last;
    logic                     r_busy;
    logic                     r_overrun;

    logic                     w_beat;
    logic [c_IDX_W-1:0]       w_next_idx;
    logic [2:0]               w_sub_next;

    assign w_beat     = r_valid & scan_ready_i;
    assign w_next_idx = r_bit_idx + 1'b1;
    assign w_sub_next = r_sub_idx + 3'd1;

`ifdef CV32E40P_RF_SCAN_CRC_EN
    logic [7:0] w_crc;
    logic [7:0] w_crc_next;
    logic       w_crc_clear;
    logic       w_crc_en;

    // Restart on an accepted capture; fold in each accepted data bit.
    assign w_crc_clear = (r_state == ST_IDLE) && capture_i;
    assign w_crc_en    = (r_state == ST_DATA) && w_beat;

    cv32e40p_rf_scan_crc8 #(
        .POLY     (CRC8_POLY)
    ) u_crc8 (
        .clk      (clk),
        .rst      (rst),
        .clear    (w_crc_clear),
        .enable   (w_crc_en),
        .bit_in   (r_dout),
        .crc      (w_crc),
        .crc_next (w_crc_next)
    );
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_shadow  <= '0;
            r_bit_idx <= '0;
            r_sub_idx <= '0;
            r_dout    <= 1'b0;
            r_valid   <= 1'b0;
            r_last    <= 1'b0;
            r_busy    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            // A request while a frame is in flight (including its final
            // beat) is dropped and remembered until reset.
            if (capture_i && r_busy) begin
                r_overrun <= 1'b1;
            end

            if (w_beat && r_last) begin
                // Final bit accepted: close the frame.
                r_state <= ST_IDLE;
                r_busy  <= 1'b0;
                r_valid <= 1'b0;
                r_last  <= 1'b0;
                r_dout  <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (capture_i) begin
                            r_shadow  <= mem_scan_i;
                            r_state   <= ST_HDR;
                            r_busy    <= 1'b1;
                            r_valid   <= 1'b1;
                            r_dout    <= HEADER[0];
                            r_last    <= 1'b0;
                            r_sub_idx <= '0;
                            r_bit_idx <= '0;
                        end
                    end

                    ST_HDR: begin
                        if (w_beat) begin
                            if (r_sub_idx == c_HDR_LAST) begin
                                r_state   <= ST_DATA;
                                r_bit_idx <= '0;
                                r_dout    <= r_shadow[0];
                                r_last    <= !c_CRC_EN && (c_DATA_BITS == 1);
                            end else begin
                                r_sub_idx <= w_sub_next;
                                r_dout    <= HEADER[w_sub_next];
                            end
                        end
                    end

                    ST_DATA: begin
                        if (w_beat) begin
`ifdef CV32E40P_RF_SCAN_CRC_EN
                            // Last data bit: w_crc_next already includes it.
                            if (r_bit_idx == c_LAST_IDX) begin
                                r_state   <= ST_CRC;
                                r_sub_idx <= '0;
                                r_dout    <= w_crc_next[0];
                                r_last    <= 1'b0;
                            end else
`endif
                            begin
                                r_bit_idx <= w_next_idx;
                                r_dout    <= r_shadow[w_next_idx];
                                r_last    <= !c_CRC_EN && (w_next_idx == c_LAST_IDX);
                            end
                        end
                    end

`ifdef CV32E40P_RF_SCAN_CRC_EN
                    ST_CRC: begin
                        // CRC register is frozen here (enable only in DATA).
                        if (w_beat) begin
                            r_sub_idx <= w_sub_next;
                            r_dout    <= w_crc[w_sub_next];
                            r_last    <= (w_sub_next == c_CRC_LAST);
                        end
                    end
`endif

                    default: begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_valid <= 1'b0;
                        r_last  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign scan_dout_o  = r_dout;
    assign scan_valid_o = r_valid;
    assign scan_last_o  = r_last;
    assign busy_o       = r_busy;
    assign overrun_o    = r_overrun;
    // Completion is flagged in the same cycle the final bit is handed off.
    assign done_o       = r_valid & r_last & scan_ready_i & ~rst;

endmodule
`default_nettype wire

// File: tb/tb_cv32e40p_rf_scan_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cv32e40p_rf_scan_reader
//  Description : Self-checking bench for cv32e40p_rf_scan_reader. Frames are
//                reassembled bit by bit and compared with a reference frame
//                built from the captured snapshot.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cv32e40p_rf_scan_reader;

    localparam int NREG  = 9;
    localparam int DW    = 32;
    localparam int DBITS = NREG * DW;
`ifdef CV32E40P_RF_SCAN_CRC_EN
    localparam int CRCB  = 8;
`else
    localparam int CRCB  = 0;
`endif
    localparam int         FRAME = 8 + DBITS + CRCB;
    localparam logic [7:0] HDR   = 8'hA5;

    typedef logic [NREG-1:0][DW-1:0] scan_t;

    typedef struct {
        int          reg_sel;
        logic [31:0] value;
        int          stall_at;   // received-bit count at which to stall
        int          stall_len;
        logic [31:0] exp_reg;
    } vec_t;

    logic  clk = 1'b0;
    logic  rst;
    scan_t mem_scan_i;
    logic  capture_i;
    logic  scan_dout_o;
    logic  scan_valid_o;
    logic  scan_ready_i;
    logic  scan_last_o;
    logic  busy_o;
    logic  done_o;
    logic  overrun_o;

    always #5 clk = ~clk;

    cv32e40p_rf_scan_reader dut (
        .clk          (clk),
        .rst          (rst),
        .mem_scan_i   (mem_scan_i),
        .capture_i    (capture_i),
        .scan_dout_o  (scan_dout_o),
        .scan_valid_o (scan_valid_o),
        .scan_ready_i (scan_ready_i),
        .scan_last_o  (scan_last_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .overrun_o    (overrun_o)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    bit    exp_q[$];
    bit    rx_q[$];
    scan_t snap;

    function automatic void build_expected(input scan_t s);
        logic [7:0] crc;
        bit         d;
        crc = 8'h00;
        exp_q.delete();
        for (int i = 0; i < 8; i++) exp_q.push_back(HDR[i]);
        for (int r = 0; r < NREG; r++) begin
            for (int b = 0; b < DW; b++) begin
                d = s[r][b];
                exp_q.push_back(d);
                crc = {crc[6:0], 1'b0} ^ ((crc[7] ^ d) ? 8'h07 : 8'h00);
            end
        end
        for (int i = 0; i < CRCB; i++) exp_q.push_back(crc[i]);
    endfunction

    function automatic scan_t rand_mem();
        scan_t m;
        for (int r = 0; r < NREG; r++) m[r] = $urandom;
        return m;
    endfunction

    // ---------------- stimulus / capture ----------------
    int last_beat, done_cnt, hold_err, drop_err, cyc_used;
    bit timed_out, done_on_last;

    // Called at posedge+1 while idle.
    task automatic start_frame(input scan_t m, input string tag);
        mem_scan_i = m;
        snap       = m;
        build_expected(m);
        capture_i  = 1'b1;
        @(posedge clk); #1;
        capture_i  = 1'b0;
        check({tag, " first_valid"}, scan_valid_o, 1);
        check({tag, " first_busy"},  busy_o, 1);
        check({tag, " first_bit"},   scan_dout_o, HDR[0]);
    endtask

    task automatic collect(input int stall_at, input int stall_len, input bit rnd_ready,
                           input bit scramble, input int cap_at, input bit cap_last,
                           input int abort_at);
        int   stall_cnt = 0;
        bit   prev_stall = 0;
        logic prev_dout = 0, prev_last = 0;
        bit   finished = 0;
        bit   cap_done = 0;
        rx_q.delete();
        last_beat = -1; done_cnt = 0; hold_err = 0; drop_err = 0; cyc_used = 0;
        timed_out = 0; done_on_last = 0;
        for (int cyc = 0; cyc < 3000 && !finished; cyc++) begin
            capture_i = 1'b0;
            if (scramble) mem_scan_i = rand_mem();
            if (rx_q.size() == stall_at && stall_cnt < stall_len) begin
                scan_ready_i = 1'b0;
                stall_cnt++;
            end else begin
                scan_ready_i = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            if (cap_at >= 0 && rx_q.size() == cap_at && !cap_done) begin
                capture_i = 1'b1;
                cap_done  = 1;
            end
            if (cap_last && scan_last_o) begin
                capture_i    = 1'b1;
                scan_ready_i = 1'b1;
            end
            if (abort_at >= 0 && rx_q.size() == abort_at) begin
                rst          = 1'b1;
                scan_ready_i = 1'b1;
            end
            #1;
            cyc_used++;
            if (done_o) done_cnt++;
            if (!scan_valid_o) drop_err++;
            if (prev_stall && (scan_dout_o !== prev_dout || scan_last_o !== prev_last)) hold_err++;
            prev_stall = scan_valid_o && !scan_ready_i;
            prev_dout  = scan_dout_o;
            prev_last  = scan_last_o;
            if (rst) begin
                finished = 1;
            end else if (scan_valid_o && scan_ready_i) begin
                rx_q.push_back(scan_dout_o);
                if (scan_last_o) begin
                    last_beat    = rx_q.size();
                    done_on_last = done_o;
                    finished     = 1;
                end
            end
            @(posedge clk); #1;
            rst = 1'b0;
        end
        if (!finished) timed_out = 1;
        capture_i    = 1'b0;
        scan_ready_i = 1'b1;
    endtask

    task automatic compare_frame(input string tag);
        int         nbad = 0;
        int         n;
        logic [7:0] hdr;
        check({tag, " timeout"}, timed_out, 0);
        check({tag, " length"}, rx_q.size(), FRAME);
        n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) if (rx_q[i] != exp_q[i]) nbad++;
        check({tag, " bad_bits"}, nbad, 0);
        hdr = 8'h00;
        for (int i = 0; i < 8 && i < rx_q.size(); i++) hdr[i] = rx_q[i];
        check({tag, " header"}, hdr, HDR);
        check({tag, " last_beat"}, last_beat, FRAME);
        check({tag, " done_count"}, done_cnt, 1);
        check({tag, " done_on_last"}, done_on_last, 1);
        check({tag, " hold"}, hold_err, 0);
        check({tag, " valid_gap"}, drop_err, 0);
        check({tag, " post_valid"}, scan_valid_o, 0);
        check({tag, " post_busy"}, busy_o, 0);
    endtask

    function automatic logic [31:0] rx_reg(input int r);
        logic [31:0] v = '0;
        for (int b = 0; b < DW; b++)
            if (8 + r * DW + b < rx_q.size()) v[b] = rx_q[8 + r * DW + b];
        return v;
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        vec_t  tv[5];
        scan_t m;
        int    idle_valid;

        tv[0] = '{0, 32'h0000_0001, -1,        0, 32'h0000_0001};
        tv[1] = '{1, 32'hFFFF_FFFF, 8 + 40,    5, 32'hFFFF_FFFF};
        tv[2] = '{8, 32'h8000_0001, 8 + 287,   3, 32'h8000_0001};
        tv[3] = '{4, 32'hDEAD_BEEF, 0,         4, 32'hDEAD_BEEF};
        tv[4] = '{2, 32'h0000_0000, -1,        0, 32'h0000_0000};

        rst = 1'b1; capture_i = 1'b0; scan_ready_i = 1'b1; mem_scan_i = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst valid",   scan_valid_o, 0);
        check("rst busy",    busy_o, 0);
        check("rst last",    scan_last_o, 0);
        check("rst dout",    scan_dout_o, 0);
        check("rst done",    done_o, 0);
        check("rst overrun", overrun_o, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("idle valid", scan_valid_o, 0);

        // Table-driven frames: one non-zero register, optional stall.
        foreach (tv[k]) begin
            m = '0;
            m[tv[k].reg_sel] = tv[k].value;
            start_frame(m, $sformatf("tv%0d", k));
            collect(tv[k].stall_at, tv[k].stall_len, 0, 0, -1, 0, -1);
            compare_frame($sformatf("tv%0d", k));
            check($sformatf("tv%0d reg", k), rx_reg(tv[k].reg_sel), tv[k].exp_reg);
            check($sformatf("tv%0d cycles", k), cyc_used, FRAME + tv[k].stall_len);
            @(posedge clk); #1;
        end

        // Back-to-back: capture in the first idle cycle after done.
        start_frame(rand_mem(), "b2b0");
        collect(-1, 0, 0, 0, -1, 0, -1);
        compare_frame("b2b0");
        start_frame(rand_mem(), "b2b1");
        collect(-1, 0, 1, 0, -1, 0, -1);
        compare_frame("b2b1");

        // Random data, random ready, scan view changing every cycle.
        for (int f = 0; f < 4; f++) begin
            start_frame(rand_mem(), $sformatf("rnd%0d", f));
            collect(-1, 0, 1, 1, -1, 0, -1);
            compare_frame($sformatf("rnd%0d", f));
            @(posedge clk); #1;
        end

        // Reset in the middle of the data section.
        start_frame(rand_mem(), "abort");
        collect(-1, 0, 0, 0, -1, 0, 8 + 150);
        check("abort bits_before_rst", rx_q.size(), 8 + 150);
        check("abort valid", scan_valid_o, 0);
        check("abort busy",  busy_o, 0);
        check("abort last",  scan_last_o, 0);
        check("abort done",  done_o, 0);
        check("abort done_count", done_cnt, 0);
        start_frame(rand_mem(), "after_abort");
        collect(-1, 0, 0, 0, -1, 0, -1);
        compare_frame("after_abort");

        // Overrun: captures mid-frame and on the final beat are ignored.
        check("ovr before", overrun_o, 0);
        start_frame(rand_mem(), "ovr");
        collect(-1, 0, 1, 1, 8 + 100, 1, -1);
        compare_frame("ovr");
        check("ovr set", overrun_o, 1);
        idle_valid = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (scan_valid_o || busy_o) idle_valid++;
        end
        check("ovr no_second_frame", idle_valid, 0);
        check("ovr sticky", overrun_o, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("ovr cleared", overrun_o, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

endmodule
`default_nettype wire
